// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, IEEE constants and the normalizer state encoding.
package fpu_pkg;

  localparam int MAN_W    = 24;
  localparam int EXP_W    = 8;
  localparam int SUM_W    = 32;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_e;

endpackage

// File: rtl/fp_twos_to_mag.sv
// Converts a two's-complement significand sum into sign plus a 25-bit magnitude.
module fp_twos_to_mag
  import fpu_pkg::*;
(
  input  logic [SUM_W-1:0] sum,
  output logic             sign,
  output logic [MAN_W:0]   mag
);

  logic [SUM_W-1:0] abs_sum;
  logic             unused_hi;

  always_comb begin
    abs_sum = sum[SUM_W-1] ? (~sum + SUM_W'(1)) : sum;
  end

  assign sign      = sum[SUM_W-1];
  assign mag       = abs_sum[MAN_W:0];
  // Bits above the 25-bit magnitude cannot carry a meaningful value for aligned significands.
  assign unused_hi = ^abs_sum[SUM_W-1:MAN_W+1];

endmodule

// File: rtl/fp_add_normalize.sv
// Adder normalize stage: iterative one-bit-per-cycle normalization and IEEE single packing.
module fp_add_normalize
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  input  logic [EXP_W-1:0] exponent,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             zero,
  output logic             overflow,
  output logic             underflow
);

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [MAN_W:0]   mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] exp_inc;
  logic [31:0]      result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             norm_done;
  logic             in_sign;
  logic [MAN_W:0]   in_mag;

  fp_twos_to_mag u_twos_to_mag (
    .sum  (sum),
    .sign (in_sign),
    .mag  (in_mag)
  );

  assign exp_inc = exp_q + EXP_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = NORM;
      NORM:    if (norm_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One normalization action per NORM cycle; the priority order decides which one fires.
  always_comb begin
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    norm_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d      = in_sign;
          mag_d       = in_mag;
          exp_d       = exponent;
          zero_d      = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          result_d  = '0;
          zero_d    = 1'b1;
          norm_done = 1'b1;
        end else if (mag_q[MAN_W]) begin
          mag_d = mag_q >> 1;
          exp_d = exp_inc;
          if (exp_inc == EXP_W'(EXP_MAX)) begin
            result_d   = sign_q ? NEG_INF : POS_INF;
            overflow_d = 1'b1;
            norm_done  = 1'b1;
          end
        end else if (mag_q[MAN_W-1]) begin
          result_d  = {sign_q, exp_q, mag_q[MAN_W-2:0]};
          norm_done = 1'b1;
        end else if (exp_q <= EXP_W'(1)) begin
          result_d    = {sign_q, 31'b0};
          underflow_d = 1'b1;
          norm_done   = 1'b1;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    zero      = zero_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Scoreboard bench for fp_add_normalize: a leading-one model predicts result, flags and latency.
module tb_fp_add_normalize;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum;
  logic [7:0]  exponent;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        underflow;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        u;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_add_normalize dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .exponent  (exponent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Predicts the outcome from the leading-one position instead of stepping cycle by cycle.
  function automatic exp_t model(input logic [31:0] s, input logic [7:0] e);
    exp_t        r;
    logic [31:0] a;
    logic [24:0] m;
    logic [24:0] mm;
    int          p;
    int          sh;
    int          e0;
    r.res = '0; r.z = 1'b0; r.o = 1'b0; r.u = 1'b0; r.lat = 2;
    a  = s[31] ? (~s + 32'd1) : s;
    m  = a[24:0];
    e0 = int'(e);
    if (m == '0) begin
      r.z = 1'b1;
      return r;
    end
    p = -1;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    if (p == 24) begin
      if (e0 + 1 == 255) begin
        r.res = s[31] ? 32'hFF80_0000 : 32'h7F80_0000;
        r.o   = 1'b1;
      end else begin
        r.res = {s[31], 8'(e0 + 1), m[23:1]};
        r.lat = 3;
      end
    end else if (p == 23) begin
      r.res = {s[31], e, m[22:0]};
    end else begin
      sh = 23 - p;
      if (e0 - sh >= 1) begin
        mm    = m << sh;
        r.res = {s[31], 8'(e0 - sh), mm[22:0]};
        r.lat = 2 + sh;
      end else begin
        r.res = {s[31], 31'b0};
        r.u   = 1'b1;
        r.lat = 2 + ((e0 <= 1) ? 0 : e0 - 1);
      end
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [31:0] s, input logic [7:0] e, input int hold);
    exp_t ex;
    int   t_acc;
    int   waited;
    bit   seen;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    sum       = s;
    exponent  = e;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    sb.push_back(model(s, e));
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    sum      = $urandom;
    exponent = 8'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    ex = sb.pop_front();
    if (!seen) begin
      checkOutput("timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
    end else begin
      checkOutput("latency", 32'(cyc - t_acc + 1), 32'(ex.lat));
      checkOutput("result", result, ex.res);
      checkOutput("zero", 32'(zero), 32'(ex.z));
      checkOutput("overflow", 32'(overflow), 32'(ex.o));
      checkOutput("underflow", 32'(underflow), 32'(ex.u));
      checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_result", result, ex.res);
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
      checkOutput("in_ready_back", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] s;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum       = '0;
    exponent  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_flags", {29'd0, zero, overflow, underflow}, 32'd0);

    applyStimulus(32'h0100_0000, 8'd127, 0);
    applyStimulus(32'h0000_0000, 8'd127, 0);
    applyStimulus(32'h0040_0000, 8'd127, 0);
    applyStimulus(32'hFF40_0000, 8'd128, 0);
    applyStimulus(32'h0100_0000, 8'd254, 0);
    applyStimulus(32'h0000_0001, 8'd3, 0);
    applyStimulus(32'hFF00_0000, 8'd254, 0);
    applyStimulus(32'h0000_0001, 8'd30, 0);
    applyStimulus(32'h0000_0001, 8'd24, 0);
    applyStimulus(32'h0080_0000, 8'd1, 0);
    applyStimulus(32'h0040_0000, 8'd1, 0);
    applyStimulus(32'hFFA0_0000, 8'd64, 5);

    // Abort in the middle of a long normalization and confirm the pending result vanishes.
    sum      = 32'h0000_0001;
    exponent = 8'd100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_flags", {29'd0, zero, overflow, underflow}, 32'd0);
    repeat (30) begin
      @(posedge clk); #1;
      checkOutput("abort_quiet", 32'(out_valid), 32'd0);
    end

    applyStimulus(32'h0180_0000, 8'd10, 0);

    for (int n = 0; n < 24; n++) begin
      s = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) s = ~s + 32'd1;
      applyStimulus(s, 8'($urandom_range(1, 254)), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
